divisor_seq: RTL and testbench

DIVISOR_SEQ -- requirements
Module: divisor_seq

---
 rtl/divisor_seq_pkg.sv | 18 +
 rtl/divisor_seq_subtrator.sv | 20 ++
 rtl/divisor_seq.sv | 121 ++++++++++++
 tb/tb_divisor_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_seq_pkg.sv
// Shared constants for the sequential divider (and its companion multiplier):
// operand widths, iteration count and the 2-bit FSM encoding.
package divisor_seq_pkg;

   localparam int DVD_W      = 32;
   localparam int DVS_W      = 16;
   localparam int ACC_W      = DVD_W + 1;
   localparam int ITERATIONS = 16;
   localparam int CNT_W      = 4;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_DIV   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/divisor_seq_subtrator.sv
// Combinational 17-bit minus 16-bit subtract; borrow set when the result is negative.
module divisor_seq_subtrator
   import divisor_seq_pkg::*;
(
   input  logic [DVS_W:0]   minuend,
   input  logic [DVS_W-1:0] subtrahend,
   output logic [DVS_W:0]   diff,
   output logic             borrow
);

   logic [DVS_W+1:0] full_s;

   // Extend by one bit so the top bit of the result is the borrow.
   always_comb begin
      full_s = {1'b0, minuend} - {2'b00, subtrahend};
      diff   = full_s[DVS_W:0];
      borrow = full_s[DVS_W+1];
   end

endmodule

// File: rtl/divisor_seq.sv
// Restoring shift-subtract divider: 32/16 unsigned, one quotient bit per clock,
// with an up-front overflow / divide-by-zero check.
module divisor_seq
   import divisor_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             St,
   input  logic [DVD_W-1:0] Dividendo,
   input  logic [DVS_W-1:0] Divisor,
   output logic [DVS_W-1:0] Quociente,
   output logic [DVS_W-1:0] Resto,
   output logic             Idle,
   output logic             Done,
   output logic             Erro
);

   logic [1:0]       state_r;
   logic [ACC_W-1:0] acc_r;
   logic [DVS_W-1:0] dvs_r;
   logic [CNT_W-1:0] cnt_r;
   logic [DVS_W-1:0] quo_r;
   logic [DVS_W-1:0] rem_r;
   logic             erro_r;
   logic             done_r;
   logic             idle_r;

   logic [ACC_W-1:0] shift_s;
   logic [ACC_W-1:0] step_s;
   logic [DVS_W:0]   diff_s;
   logic             borrow_s;
   logic             ovf_s;

   divisor_seq_subtrator subtrator (
      .minuend    (shift_s[ACC_W-1:DVS_W]),
      .subtrahend (dvs_r),
      .diff       (diff_s),
      .borrow     (borrow_s)
   );

   // One restoring step; a high part >= divisor means the quotient cannot fit in 16 bits.
   always_comb begin
      shift_s = acc_r << 1;
      step_s  = shift_s;
      if (!borrow_s) begin
         step_s = {diff_s, shift_s[DVS_W-1:1], 1'b1};
      end else begin
         step_s = shift_s;
      end
      ovf_s = (acc_r[DVD_W-1:DVS_W] >= dvs_r);
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
         acc_r   <= {ACC_W{1'b0}};
         dvs_r   <= {DVS_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         quo_r   <= {DVS_W{1'b0}};
         rem_r   <= {DVS_W{1'b0}};
         erro_r  <= 1'b0;
         done_r  <= 1'b0;
         idle_r  <= 1'b1;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (St) begin
                  acc_r   <= {1'b0, Dividendo};
                  dvs_r   <= Divisor;
                  cnt_r   <= {CNT_W{1'b0}};
                  erro_r  <= 1'b0;
                  idle_r  <= 1'b0;
                  state_r <= S_CHECK;
               end else begin
                  idle_r  <= 1'b1;
               end
            end
            S_CHECK: begin
               if (ovf_s) begin
                  erro_r  <= 1'b1;
                  quo_r   <= 16'hFFFF;
                  rem_r   <= 16'h0000;
                  done_r  <= 1'b1;
                  state_r <= S_DONE;
               end else begin
                  state_r <= S_DIV;
               end
            end
            S_DIV: begin
               acc_r <= step_s;
               cnt_r <= cnt_r + 4'd1;
               if (cnt_r == CNT_LAST) begin
                  quo_r   <= step_s[DVS_W-1:0];
                  rem_r   <= step_s[DVD_W-1:DVS_W];
                  done_r  <= 1'b1;
                  state_r <= S_DONE;
               end else begin
                  state_r <= S_DIV;
               end
            end
            S_DONE: begin
               idle_r  <= 1'b1;
               state_r <= S_IDLE;
            end
            default: begin
               idle_r  <= 1'b1;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign Quociente = quo_r;
   assign Resto     = rem_r;
   assign Erro      = erro_r;
   assign Done      = done_r;
   assign Idle      = idle_r;

endmodule

// File: tb/tb_divisor_seq.sv
// Directed and random checks of divisor_seq: results, Done latency, error path,
// input isolation while busy, reset abort and back-to-back operation.
module tb_divisor_seq;

   logic        clk;
   logic        rst;
   logic        St;
   logic [31:0] Dividendo;
   logic [15:0] Divisor;
   logic [15:0] Quociente;
   logic [15:0] Resto;
   logic        Idle;
   logic        Done;
   logic        Erro;

   int checks = 0;
   int errors = 0;

   divisor_seq dut (
      .clk       (clk),
      .rst       (rst),
      .St        (St),
      .Dividendo (Dividendo),
      .Divisor   (Divisor),
      .Quociente (Quociente),
      .Resto     (Resto),
      .Idle      (Idle),
      .Done      (Done),
      .Erro      (Erro)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus only: start one operation and report Done latency (edges after acceptance) and pulse count.
   task automatic run_op(input logic [31:0] a, input logic [15:0] b, output int lat, output int ndone);
      @(negedge clk);
      Dividendo = a;
      Divisor   = b;
      St        = 1'b1;
      @(posedge clk);
      @(negedge clk);
      St    = 1'b0;
      lat   = -1;
      ndone = 0;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (Done) begin
            if (lat < 0) lat = k;
            ndone++;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      St = 1'b0;
      Dividendo = 32'd0;
      Divisor = 16'd0;
      #12;
      checks += 5;
      if (Quociente !== 16'd0) begin errors++; $display("FAIL reset_q: got %0h expected 0", Quociente); end
      if (Resto !== 16'd0) begin errors++; $display("FAIL reset_r: got %0h expected 0", Resto); end
      if (Idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %0b expected 1", Idle); end
      if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", Done); end
      if (Erro !== 1'b0) begin errors++; $display("FAIL reset_erro: got %0b expected 0", Erro); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic;
      int lat, nd;
      run_op(32'd100, 16'd7, lat, nd);
      checks += 5;
      if (lat !== 17) begin errors++; $display("FAIL basic_lat: got %0d expected 17", lat); end
      if (nd !== 1) begin errors++; $display("FAIL basic_ndone: got %0d expected 1", nd); end
      if (Quociente !== 16'd14) begin errors++; $display("FAIL basic_q: got %0d expected 14", Quociente); end
      if (Resto !== 16'd2) begin errors++; $display("FAIL basic_r: got %0d expected 2", Resto); end
      if (Erro !== 1'b0) begin errors++; $display("FAIL basic_erro: got %0b expected 0", Erro); end
   endtask

   task automatic test_max;
      int lat, nd;
      run_op(32'hFFFE0001, 16'hFFFF, lat, nd);
      checks += 4;
      if (lat !== 17) begin errors++; $display("FAIL max_lat: got %0d expected 17", lat); end
      if (Quociente !== 16'hFFFF) begin errors++; $display("FAIL max_q: got %0h expected ffff", Quociente); end
      if (Resto !== 16'h0000) begin errors++; $display("FAIL max_r: got %0h expected 0", Resto); end
      if (Erro !== 1'b0) begin errors++; $display("FAIL max_erro: got %0b expected 0", Erro); end
      // Largest dividend that still fits with divisor 5: 327679 = 5*65535 + 4
      run_op(32'h0004FFFF, 16'd5, lat, nd);
      checks += 3;
      if (Quociente !== 16'hFFFF) begin errors++; $display("FAIL edge_q: got %0h expected ffff", Quociente); end
      if (Resto !== 16'd4) begin errors++; $display("FAIL edge_r: got %0h expected 4", Resto); end
      if (Erro !== 1'b0) begin errors++; $display("FAIL edge_erro: got %0b expected 0", Erro); end
   endtask

   task automatic test_error;
      int lat, nd;
      run_op(32'd12345, 16'd0, lat, nd);
      checks += 5;
      if (lat !== 1) begin errors++; $display("FAIL dz_lat: got %0d expected 1", lat); end
      if (nd !== 1) begin errors++; $display("FAIL dz_ndone: got %0d expected 1", nd); end
      if (Erro !== 1'b1) begin errors++; $display("FAIL dz_erro: got %0b expected 1", Erro); end
      if (Quociente !== 16'hFFFF) begin errors++; $display("FAIL dz_q: got %0h expected ffff", Quociente); end
      if (Resto !== 16'h0000) begin errors++; $display("FAIL dz_r: got %0h expected 0", Resto); end
      run_op(32'h00050000, 16'd5, lat, nd);
      checks += 4;
      if (lat !== 1) begin errors++; $display("FAIL ovf_lat: got %0d expected 1", lat); end
      if (Erro !== 1'b1) begin errors++; $display("FAIL ovf_erro: got %0b expected 1", Erro); end
      if (Quociente !== 16'hFFFF) begin errors++; $display("FAIL ovf_q: got %0h expected ffff", Quociente); end
      if (Resto !== 16'h0000) begin errors++; $display("FAIL ovf_r: got %0h expected 0", Resto); end
   endtask

   task automatic test_ignore_inputs;
      int lat, nd;
      lat = -1;
      nd = 0;
      @(negedge clk);
      Dividendo = 32'd1000000;
      Divisor = 16'd123;
      St = 1'b1;
      @(posedge clk);
      @(negedge clk);
      St = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (Done) begin
            if (lat < 0) lat = k;
            nd++;
         end
         if (k == 5) begin
            St = 1'b1;
            Dividendo = 32'd5;
            Divisor = 16'd1;
         end
         if (k == 10) St = 1'b0;
      end
      checks += 5;
      if (lat !== 17) begin errors++; $display("FAIL ign_lat: got %0d expected 17", lat); end
      if (nd !== 1) begin errors++; $display("FAIL ign_ndone: got %0d expected 1", nd); end
      if (Quociente !== 16'd8130) begin errors++; $display("FAIL ign_q: got %0d expected 8130", Quociente); end
      if (Resto !== 16'd10) begin errors++; $display("FAIL ign_r: got %0d expected 10", Resto); end
      if (Erro !== 1'b0) begin errors++; $display("FAIL ign_erro: got %0b expected 0", Erro); end
   endtask

   task automatic test_reset_mid_div;
      int lat, nd;
      nd = 0;
      @(negedge clk);
      Dividendo = 32'd50000000;
      Divisor = 16'd1000;
      St = 1'b1;
      @(posedge clk);
      @(negedge clk);
      St = 1'b0;
      // DIV iteration 8 happens on the 9th edge after acceptance
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (Done) nd++;
      end
      checks += 1;
      if (Idle !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b expected 0", Idle); end
      #2;
      rst = 1'b0;
      #1;
      checks += 4;
      if (Quociente !== 16'd0) begin errors++; $display("FAIL rmid_q: got %0h expected 0", Quociente); end
      if (Resto !== 16'd0) begin errors++; $display("FAIL rmid_r: got %0h expected 0", Resto); end
      if (Idle !== 1'b1) begin errors++; $display("FAIL rmid_idle: got %0b expected 1", Idle); end
      if (Erro !== 1'b0) begin errors++; $display("FAIL rmid_erro: got %0b expected 0", Erro); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (Done) nd++;
      end
      checks += 1;
      if (nd !== 0) begin errors++; $display("FAIL rmid_nodone: got %0d expected 0", nd); end
      run_op(32'd0, 16'd3, lat, nd);
      checks += 3;
      if (lat !== 17) begin errors++; $display("FAIL rmid_new_lat: got %0d expected 17", lat); end
      if (Quociente !== 16'd0) begin errors++; $display("FAIL rmid_new_q: got %0h expected 0", Quociente); end
      if (Resto !== 16'd0) begin errors++; $display("FAIL rmid_new_r: got %0h expected 0", Resto); end
   endtask

   task automatic test_back_to_back;
      int d1, d2;
      d1 = -1;
      d2 = -1;
      @(negedge clk);
      Dividendo = 32'd100;
      Divisor = 16'd7;
      St = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (Done) begin
            if (d1 < 0) d1 = k;
            else if (d2 < 0) d2 = k;
         end
         if (k == 17) begin
            checks += 2;
            if (Quociente !== 16'd14) begin errors++; $display("FAIL b2b_q1: got %0d expected 14", Quociente); end
            if (Resto !== 16'd2) begin errors++; $display("FAIL b2b_r1: got %0d expected 2", Resto); end
            Dividendo = 32'd1000;
            Divisor = 16'd10;
         end
         if (k == 18) begin
            checks += 1;
            if (Idle !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %0b expected 1", Idle); end
         end
         if (k == 19) begin
            checks += 1;
            if (Idle !== 1'b0) begin errors++; $display("FAIL b2b_accept: got %0b expected 0", Idle); end
            St = 1'b0;
         end
      end
      checks += 4;
      if (d1 !== 17) begin errors++; $display("FAIL b2b_d1: got %0d expected 17", d1); end
      if (d2 !== 36) begin errors++; $display("FAIL b2b_d2: got %0d expected 36", d2); end
      if (Quociente !== 16'd100) begin errors++; $display("FAIL b2b_q2: got %0d expected 100", Quociente); end
      if (Resto !== 16'd0) begin errors++; $display("FAIL b2b_r2: got %0d expected 0", Resto); end
   endtask

   task automatic test_random;
      int lat, nd;
      logic [31:0] a;
      logic [15:0] b;
      logic [15:0] hi;
      logic [47:0] recon;
      for (int i = 0; i < 200; i++) begin
         b = 16'($urandom_range(1, 65535));
         hi = 16'($urandom_range(0, int'(b) - 1));
         a = {hi, 16'($urandom_range(0, 65535))};
         run_op(a, b, lat, nd);
         recon = 48'(Quociente) * 48'(b) + 48'(Resto);
         checks += 6;
         if (lat !== 17) begin errors++; $display("FAIL rnd_lat: got %0d expected 17 (%0h/%0h)", lat, a, b); end
         if (nd !== 1) begin errors++; $display("FAIL rnd_ndone: got %0d expected 1", nd); end
         if (recon !== 48'(a)) begin errors++; $display("FAIL rnd_identity: got %0h expected %0h (b=%0h)", recon, a, b); end
         if (Resto >= b) begin errors++; $display("FAIL rnd_rem_bound: got %0h expected below %0h", Resto, b); end
         if (Quociente !== 16'(a / 32'(b))) begin errors++; $display("FAIL rnd_q: got %0h expected %0h", Quociente, a / 32'(b)); end
         if (Erro !== 1'b0) begin errors++; $display("FAIL rnd_erro: got %0b expected 0", Erro); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_error();
      test_basic();
      test_ignore_inputs();
      test_reset_mid_div();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
